// File: rtl/latch_bank_ctrl_pkg.sv
// latch_bank_ctrl_pkg: shared state encoding and width helper for latch_bank_ctrl
package latch_bank_ctrl_pkg;
  localparam int STATE_W = 2;
  typedef enum logic [STATE_W-1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_e;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/lbc_arbiter.sv
// lbc_arbiter: write-request winner select, round-robin pointer under LATCH_BANK_CTRL_RR_EN, else fixed priority
module lbc_arbiter
  import latch_bank_ctrl_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  input  logic               adv,
  output logic [NUM_REQ-1:0] win_oh,
  output logic [IW-1:0]      win_idx
);
  logic [IW-1:0] ptr;
  int            idx_c;
  logic          found_c;
`ifdef LATCH_BANK_CTRL_RR_EN
  logic [IW-1:0] ptr_q, ptr_d;
  // Pointer moves just past the winner on every grant
  always_comb ptr_d = adv ? IW'((int'(win_idx) + 1) % NUM_REQ) : ptr_q;
  // Pointer register
  always_ff @(posedge clk or posedge reset)
    if (reset) ptr_q <= '0;
    else ptr_q <= ptr_d;
  assign ptr = ptr_q;
`else
  logic unused_ok;
  assign unused_ok = ^{clk, reset, adv};
  assign ptr = '0;
`endif
  // Scan requesters starting at the pointer; the first one found wins
  always_comb begin
    win_idx = '0;
    found_c = 1'b0;
    idx_c = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx_c = (int'(ptr) + k) % NUM_REQ;
      if (!found_c && req[idx_c]) begin
        win_idx = IW'(idx_c);
        found_c = 1'b1;
      end
    end
    win_oh = found_c ? NUM_REQ'(1) << win_idx : '0;
  end
endmodule

// File: rtl/latch_bank_ctrl.sv
// latch_bank_ctrl: arbitrated setup/strobe/hold write sequencer and registered read select for a latch bank (LATCH_BANK_CTRL_RR_EN selects round-robin)
module latch_bank_ctrl
  import latch_bank_ctrl_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int NUM_REQ = 4,
  parameter int NUM_LATCH = 4,
  localparam int AW = idx_w(NUM_LATCH),
  localparam int IW = idx_w(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*AW-1:0]    req_addr,
  input  logic [NUM_REQ*WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       done,
  output logic                     err,
  output logic                     busy,
  output logic [WIDTH-1:0]         latch_data,
  output logic [NUM_LATCH-1:0]     latch_le,
  input  logic                     rd_en,
  input  logic [AW-1:0]            rd_addr,
  output logic [NUM_LATCH-1:0]     latch_oen
);
  localparam logic [AW:0] NL = (AW+1)'(NUM_LATCH);
  state_e               state_q, state_d;
  logic [IW-1:0]        widx_q, widx_d;
  logic [AW-1:0]        addr_q, addr_d;
  logic [WIDTH-1:0]     data_q, data_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d, done_q, done_d, win_oh;
  logic [NUM_LATCH-1:0] le_q, le_d, oen_q, oen_d;
  logic                 err_q, err_d, busy_q, busy_d, addr_ok, rd_ok;
  logic [IW-1:0]        win_idx;
  assign addr_ok = {1'b0, addr_q} < NL;
  assign rd_ok   = {1'b0, rd_addr} < NL;
  lbc_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .adv     (state_q == IDLE && |req),
    .win_oh  (win_oh),
    .win_idx (win_idx)
  );
  // Write sequence: capture in IDLE, grant in SETUP, enable in STROBE, complete in HOLD
  always_comb begin
    state_d = state_q;
    widx_d  = widx_q;
    addr_d  = addr_q;
    data_d  = data_q;
    gnt_d   = '0;
    done_d  = '0;
    err_d   = 1'b0;
    le_d    = '0;
    case (state_q)
      IDLE: if (|req) begin
        state_d = SETUP;
        widx_d  = win_idx;
        addr_d  = req_addr[win_idx*AW +: AW];
        data_d  = req_data[win_idx*WIDTH +: WIDTH];
        gnt_d   = win_oh;
      end
      SETUP: begin
        state_d = STROBE;
        le_d    = addr_ok ? NUM_LATCH'(1) << addr_q : '0;
      end
      STROBE: begin
        state_d = HOLD;
        done_d  = NUM_REQ'(1) << widx_q;
        err_d   = !addr_ok;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
    oen_d  = (rd_en && rd_ok) ? ~(NUM_LATCH'(1) << rd_addr) : '1;
  end
  // All state and outputs registered; reset drops the enable without waiting for a clock
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q <= IDLE;
      widx_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= 1'b0;
      le_q    <= '0;
      busy_q  <= 1'b0;
      oen_q   <= '1;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      le_q    <= le_d;
      busy_q  <= busy_d;
      oen_q   <= oen_d;
    end
  assign gnt        = gnt_q;
  assign done       = done_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign latch_data = data_q;
  assign latch_le   = le_q;
  assign latch_oen  = oen_q;
endmodule

// File: tb/tb_latch_bank_ctrl.sv
// tb_latch_bank_ctrl: scoreboard bench for latch_bank_ctrl (expects LATCH_BANK_CTRL_RR_EN ordering when defined)
module tb_latch_bank_ctrl;
  typedef struct packed {
    logic [3:0] gnt;
    logic [3:0] le;
    logic [7:0] data;
    logic       err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [3:0]  req, gnt, done, latch_le, latch_oen;
  logic [7:0]  req_addr;
  logic [31:0] req_data;
  logic [7:0]  latch_data;
  logic        err, busy, rd_en;
  logic [1:0]  rd_addr;

  logic [0:0]  req3, gnt3, done3;
  logic [1:0]  req_addr3, rd_addr3;
  logic [7:0]  req_data3, ld3;
  logic        err3, busy3, rd_en3;
  logic [2:0]  le3, oen3;

  latch_bank_ctrl dut (
    .clk(clk), .reset(reset), .req(req), .req_addr(req_addr), .req_data(req_data),
    .gnt(gnt), .done(done), .err(err), .busy(busy), .latch_data(latch_data),
    .latch_le(latch_le), .rd_en(rd_en), .rd_addr(rd_addr), .latch_oen(latch_oen)
  );

  latch_bank_ctrl #(.WIDTH(8), .NUM_REQ(1), .NUM_LATCH(3)) dut3 (
    .clk(clk), .reset(reset), .req(req3), .req_addr(req_addr3), .req_data(req_data3),
    .gnt(gnt3), .done(done3), .err(err3), .busy(busy3), .latch_data(ld3),
    .latch_le(le3), .rd_en(rd_en3), .rd_addr(rd_addr3), .latch_oen(oen3)
  );

  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  logic mon_en = 1'b1;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, want);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input int r, input int a, input logic [7:0] d, input logic push);
    exp_t e;
    req_addr[r*2 +: 2] = 2'(a);
    req_data[r*8 +: 8] = d;
    req[r] = 1'b1;
    e.gnt  = 4'b0001 << r;
    e.le   = 4'b0001 << a;
    e.data = d;
    e.err  = 1'b0;
    if (push) exp_q.push_back(e);
  endtask

  always @(negedge clk) if (done != 4'b0) done_cnt++;

  // Monitor: a grant pulse starts one transaction; follow it through strobe and completion
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (mon_en && gnt != 4'b0) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_gnt: got %0h expected none", gnt);
      end else begin
        e = exp_q.pop_front();
        check("setup_gnt", 32'(gnt), 32'(e.gnt));
        check("setup_le", 32'(latch_le), 32'h0);
        check("setup_data", 32'(latch_data), 32'(e.data));
        check("setup_busy", 32'(busy), 32'h1);
        @(negedge clk);
        check("strobe_le", 32'(latch_le), 32'(e.le));
        check("strobe_data", 32'(latch_data), 32'(e.data));
        check("strobe_gnt", 32'(gnt), 32'h0);
        @(negedge clk);
        check("hold_done", 32'(done), 32'(e.gnt));
        check("hold_err", 32'(err), 32'(e.err));
        check("hold_le", 32'(latch_le), 32'h0);
        check("hold_data", 32'(latch_data), 32'(e.data));
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    int base, le3_hi, both, err_n, done_n;
    req = '0; req_addr = '0; req_data = '0; rd_en = 1'b0; rd_addr = '0;
    req3 = '0; req_addr3 = '0; req_data3 = '0; rd_en3 = 1'b0; rd_addr3 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_le", 32'(latch_le), 32'h0);
    check("rst_data", 32'(latch_data), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_oen", 32'(latch_oen), 32'hF);
    reset = 1'b0;
    tick();
    issue(1, 2, 8'hA5, 1'b1);
    tick();
    req = '0;
    tick(4);
    check("idle_data_kept", 32'(latch_data), 32'hA5);
    check("idle_busy", 32'(busy), 32'h0);
    issue(1, 0, 8'h5A, 1'b1);
    tick();
    req = '0;
    req_data[15:8] = 8'h3C;
    req_addr[3:2] = 2'd3;
    tick(4);
    rd_en = 1'b1;
    rd_addr = 2'd1;
    issue(2, 1, 8'h77, 1'b1);
    tick();
    req = '0;
    check("oen_rd1", 32'(latch_oen), 32'hD);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("oen_rd1_during_write", 32'(latch_oen), 32'hD);
    end
    rd_en = 1'b0;
    tick();
    check("oen_rd_off", 32'(latch_oen), 32'hF);
    rd_en = 1'b1;
    rd_addr = 2'd3;
    tick();
    check("oen_rd3", 32'(latch_oen), 32'h7);
    rd_en = 1'b0;
    tick();
    mon_en = 1'b0;
    issue(2, 3, 8'hC3, 1'b0);
    tick();
    req = '0;
    tick();
    check("abort_strobe_le", 32'(latch_le), 32'h8);
    base = done_cnt;
    #2 reset = 1'b1;
    #1;
    check("abort_le_async", 32'(latch_le), 32'h0);
    check("abort_busy_async", 32'(busy), 32'h0);
    #2 reset = 1'b0;
    tick(4);
    check("abort_no_done", 32'(done_cnt), 32'(base));
    mon_en = 1'b1;
    issue(3, 3, 8'hE1, 1'b1);
    tick();
    req = '0;
    tick(4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      req_addr[i*2 +: 2] = 2'(i);
      req_data[i*8 +: 8] = 8'h10 + 8'(i);
    end
    for (int g = 0; g < 5; g++) begin
      exp_t e;
`ifdef LATCH_BANK_CTRL_RR_EN
      e.gnt = 4'b0001 << (g % 4);
      e.le = 4'b0001 << (g % 4);
      e.data = 8'h10 + 8'(g % 4);
`else
      e.gnt = 4'b0001;
      e.le = 4'b0001;
      e.data = 8'h10;
`endif
      e.err = 1'b0;
      exp_q.push_back(e);
    end
    req = 4'b1111;
    tick(20);
    req = '0;
    tick(5);
    req_addr3 = 2'd3;
    req_data3 = 8'h99;
    req3 = 1'b1;
    tick();
    req3 = 1'b0;
    le3_hi = 0; both = 0; err_n = 0; done_n = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (le3 != 3'b0) le3_hi++;
      if (err3 && done3[0]) both++;
      if (err3) err_n++;
      if (done3[0]) done_n++;
    end
    check("oor_no_le", 32'(le3_hi), 32'h0);
    check("oor_err_with_done", 32'(both), 32'h1);
    check("oor_err_count", 32'(err_n), 32'h1);
    check("oor_done_count", 32'(done_n), 32'h1);
    rd_en3 = 1'b1;
    rd_addr3 = 2'd3;
    tick();
    check("oor_rd_oen", 32'(oen3), 32'h7);
    rd_addr3 = 2'd2;
    tick();
    check("rd2_oen3", 32'(oen3), 32'h3);
    check("scoreboard_empty", 32'(exp_q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/latch_bank_ctrl.md
# latch_bank_ctrl

Write sequencer and arbiter for a bank of NUM_LATCH level-sensitive n-bit latches sharing one data bus. It accepts write requests from NUM_REQ requesters, arbitrates, and drives a clean setup / strobe / hold sequence on the shared bus so each latch enable is a single, glitch-free, one-cycle pulse. It also generates per-latch active-low output enables for a registered read select. It sits between the requesting units and the latch bank, replacing ad-hoc direct strobing of latch enables.

## Interface
- WIDTH, 8, data width of each latch
- NUM_REQ, 4, number of write requesters (≥1)
- NUM_LATCH, 4, number of latches in the bank (≥2); AW = $clog2(NUM_LATCH)

- clk  in  1  single clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- req  in  NUM_REQ  write request per requester, level
- req_addr  in  NUM_REQ*AW  target latch index, requester i at [i*AW +: AW]
- req_data  in  NUM_REQ*WIDTH  write data, requester i at [i*WIDTH +: WIDTH]
- gnt  out  NUM_REQ  one-hot grant pulse, one cycle
- done  out  NUM_REQ  one-hot completion pulse, one cycle
- err  out  1  pulses with done when the granted address ≥ NUM_LATCH
- busy  out  1  high whenever the FSM is not IDLE
- latch_data  out  WIDTH  shared bus to all latch data inputs
- latch_le  out  NUM_LATCH  per-latch enable, at most one bit high
- rd_en  in  1  read select valid
- rd_addr  in  AW  latch to enable onto the read bus
- latch_oen  out  NUM_LATCH  per-latch output enable, active low, at most one bit low

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD. Encoding is in the package.
- IDLE: if any req is high, select winner; at that edge register winner index, req_addr, req_data; go SETUP. Otherwise stay.
- SETUP: latch_data = captured data; latch_le all 0; gnt[winner]=1; go STROBE.
- STROBE: latch_le[addr]=1 if addr < NUM_LATCH, else all 0; latch_data held; go HOLD.
- HOLD: latch_le all 0; latch_data held; done[winner]=1; err=1 if addr out of range; go IDLE.
- Requester data/addr only needs to be valid at the IDLE→SETUP edge. Dropping req after that does not abort the transaction.
- A requester still holding req in the cycle after done is treated as a new request.
- latch_data keeps its last driven value in IDLE. It is not zeroed.
- Read path is independent of the FSM. A registered latch_oen updates every cycle: if rd_en, bit rd_addr = 0 and all others = 1; else all 1. An out-of-range rd_addr gives all 1.
- Simultaneous read and write of the same latch is legal; le and oen are driven independently.

## Timing
- Reset values: state IDLE; gnt, done, err, latch_le, latch_data = 0; busy = 0; latch_oen = all 1; arbitration pointer = 0.
- Asserting reset mid-transaction drops latch_le immediately (async) and returns to IDLE. No done is issued for that transaction.
- Fixed 4-cycle write period: req seen at edge n, gnt in cycle n+1, latch_le in cycle n+2, done in cycle n+3, IDLE in n+4. Next arbitration happens at the end of cycle n+4. Maximum throughput is one write per 4 cycles.
- latch_data is stable for one full cycle before and after the latch_le pulse.
- Read latency: rd_en/rd_addr at edge n → latch_oen valid in cycle n+1.
- All outputs are registered. No combinational path runs from inputs to outputs.

## Configuration
- LATCH_BANK_CTRL_RR_EN defined: round-robin arbitration. The pointer advances to (winner+1) mod NUM_REQ on each grant, and the search starts at the pointer.
- Undefined: fixed priority, where the lowest index wins. The pointer register is not built.

## Structure
- latch_bank_ctrl_pkg holds:
  - the state enum typedef
  - the state width constant
  - a function for AW
- Sub-module lbc_arbiter holds the combinational winner select plus the optional round-robin pointer (guarded by the macro). Its inputs are req and an advance strobe; its outputs are a one-hot winner and its index.
- FSM, capture registers and read-enable register live in latch_bank_ctrl.

## Test plan
- Reset then single write: req[1]=1, addr=2, data=8'hA5. Required response:
  - gnt[1] one cycle later
  - latch_le=4'b0100 the next cycle, with latch_data=A5 in the cycles before, during and after
  - done[1] in the following cycle, err=0
- Contention with req=4'b1111 held: with RR_EN, grants go 0,1,2,3,0 at 4-cycle spacing; without it, requester 0 is granted repeatedly.
- Out-of-range: NUM_LATCH=3, addr=3. Required response: no latch_le bit ever high; err and done pulse together.
- Read select: rd_en=1, rd_addr=1 gives latch_oen=4'b1101 one cycle later. rd_en=0 gives 4'b1111. This must hold during an active write to latch 1.
- Reset asserted during STROBE: latch_le goes to 0 with no clock edge, busy goes to 0, and no done is issued. The next request then completes normally.
- Requester drops req and changes req_data right after the IDLE→SETUP edge: latch_data still carries the originally captured value, and done is still issued.
